// File: rtl/unified_mem_arbiter_if.sv
// CPU fetch/data ports and shared-memory bus of the unified memory arbiter.
// slave = arbiter side, master = CPU pipeline plus memory as seen from outside.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              d_rd_en;
    logic              d_wr_en;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_type;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_type;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              timeout_err;

    modport slave (
        input  if_req, if_addr, d_rd_en, d_wr_en, d_addr, d_wdata, d_type, mem_ack, mem_rdata,
        output if_rdata, if_valid, d_rdata, d_valid, stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_type, timeout_err
    );

    modport master (
        output if_req, if_addr, d_rd_en, d_wr_en, d_addr, d_wdata, d_type, mem_ack, mem_rdata,
        input  if_rdata, if_valid, d_rdata, d_valid, stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_type, timeout_err
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one variable-latency memory between fetch and data ports; data wins, fetch gets a turn after STARVE_LIM data grants.
// Request-to-valid is ack latency + 1 (min 2 cycles); stall holds the pipeline until its x_valid pulse.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_WAIT   = 15,
    parameter int STARVE_LIM = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    unified_mem_arbiter_if.slave  bus
);
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam int STARVE_W = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [STARVE_W-1:0] r_starve;
    logic [STARVE_W-1:0] w_starve_nxt;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_type;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_valid;
    logic              r_d_valid;
    logic              r_timeout;

    logic w_d_req;
    logic w_if_elig;
    logic w_d_elig;
    logic w_starved;
    logic w_grant_if;
    logic w_grant_d;
    logic w_busy;
    logic w_done;
    logic w_abort;
    logic w_end;

    // A port whose valid is high is ineligible; if that port is data and still
    // requesting, fetch does not sneak in unless it is starved.
    assign w_d_req    = bus.d_rd_en | bus.d_wr_en;
    assign w_if_elig  = bus.if_req & ~r_if_valid;
    assign w_d_elig   = w_d_req & ~r_d_valid;
    assign w_starved  = w_if_elig & (r_starve == STARVE_W'(STARVE_LIM));
    assign w_grant_if = (r_state == IDLE) & w_if_elig & (w_starved | ~w_d_req);
    assign w_grant_d  = (r_state == IDLE) & w_d_elig & ~w_starved;

    assign w_busy  = (r_state != IDLE);
    assign w_done  = w_busy & bus.mem_ack;
    assign w_abort = w_busy & ~bus.mem_ack & (r_wait == WAIT_W'(MAX_WAIT - 1));
    assign w_end   = w_done | w_abort;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_wait   <= '0;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wait   <= w_wait_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wait_nxt   = '0;
        w_starve_nxt = r_starve;
        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = BUSY_D;
                end else if (w_grant_if) begin
                    w_state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (w_end) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_grant_if) begin
            w_starve_nxt = '0;
        end else if (w_grant_d && bus.if_req && (r_starve != STARVE_W'(STARVE_LIM))) begin
            w_starve_nxt = r_starve + STARVE_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_type     <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_if_valid <= (r_state == BUSY_IF) & w_end;
            r_d_valid  <= (r_state == BUSY_D) & w_end;
            if (w_abort) begin
                r_timeout <= 1'b1;
            end
            if ((r_state == BUSY_IF) && w_end) begin
                r_if_rdata <= w_done ? bus.mem_rdata : '0;
            end
            // Stores leave the load data register untouched, even on abort.
            if ((r_state == BUSY_D) && w_end && !r_we) begin
                r_d_rdata <= w_done ? bus.mem_rdata : '0;
            end
            if (w_grant_d) begin
                r_we    <= bus.d_wr_en;
                r_addr  <= bus.d_addr;
                r_wdata <= bus.d_wr_en ? bus.d_wdata : '0;
                r_type  <= bus.d_type;
            end else if (w_grant_if) begin
                r_we    <= 1'b0;
                r_addr  <= bus.if_addr;
                r_wdata <= '0;
                r_type  <= 3'b010;
            end
        end
    end

    assign bus.mem_req     = w_busy;
    assign bus.mem_we      = r_we;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wdata   = r_wdata;
    assign bus.mem_type    = r_type;
    assign bus.if_rdata    = r_if_rdata;
    assign bus.if_valid    = r_if_valid;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.d_valid     = r_d_valid;
    assign bus.timeout_err = r_timeout;
    assign bus.stall       = (bus.if_req & ~r_if_valid) | (w_d_req & ~r_d_valid);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: requester/memory models feed scoreboard queues
// that are checked on every memory grant and every valid pulse.
module tb_unified_mem_arbiter;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  typ;
    } txn_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  typ;
    } dcmd_t;

    typedef struct {
        logic        is_store;
        logic [31:0] rdata;
    } dexp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(15), .STARVE_LIM(4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          ack_after   = 2;
    int          last_len    = 0;
    logic        idle_ack    = 1'b0;
    logic [31:0] exp_last    = 32'h0;

    logic [31:0] f_q[$];
    dcmd_t       d_q[$];
    txn_t        exp_txn_q[$];
    logic [31:0] exp_if_q[$];
    dexp_t       exp_d_q[$];
    int          done_log[$];

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a, input logic [31:0] rdata);
        txn_t t;
        t.we = 1'b0; t.addr = a; t.wdata = 32'h0; t.typ = 3'b010;
        f_q.push_back(a);
        exp_txn_q.push_back(t);
        exp_if_q.push_back(rdata);
    endtask

    task automatic push_data(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] ty, input logic expect_valid);
        dcmd_t c;
        txn_t  t;
        dexp_t e;
        c.rd = rd; c.wr = wr; c.addr = a; c.wdata = wd; c.typ = ty;
        t.we = wr; t.addr = a; t.wdata = wr ? wd : 32'h0; t.typ = ty;
        e.is_store = wr; e.rdata = mem_model(a);
        d_q.push_back(c);
        exp_txn_q.push_back(t);
        if (expect_valid) exp_d_q.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        int pending;
        pending = 1;
        for (int i = 0; i < budget && pending != 0; i++) begin
            @(negedge clk); #2;
            pending = f_q.size() + d_q.size() + exp_if_q.size() + exp_d_q.size() + exp_txn_q.size()
                    + int'(bus.if_req) + int'(bus.d_rd_en | bus.d_wr_en) + int'(bus.mem_req);
        end
        chk({tag, "_drain"}, pending, 0);
    endtask

    // Fetch requester: holds if_req/if_addr until if_valid, then advances.
    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) bus.if_req = 1'b0;
            else if (!bus.if_req || bus.if_valid) begin
                if (f_q.size() != 0) begin
                    bus.if_req = 1'b1; bus.if_addr = f_q.pop_front();
                end else bus.if_req = 1'b0;
            end
        end
    end

    // Load/store requester with the same hold-until-valid behaviour.
    initial begin
        dcmd_t c;
        bus.d_rd_en = 1'b0; bus.d_wr_en = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_type = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.d_rd_en = 1'b0; bus.d_wr_en = 1'b0;
            end else if (!(bus.d_rd_en || bus.d_wr_en) || bus.d_valid) begin
                if (d_q.size() != 0) begin
                    c = d_q.pop_front();
                    bus.d_rd_en = c.rd; bus.d_wr_en = c.wr; bus.d_addr = c.addr;
                    bus.d_wdata = c.wdata; bus.d_type = c.typ;
                end else begin
                    bus.d_rd_en = 1'b0; bus.d_wr_en = 1'b0;
                end
            end
        end
    end

    // Memory: checks each transaction on its first mem_req cycle, acks on cycle ack_after (0 = never).
    initial begin
        int   cnt;
        txn_t t;
        cnt = 0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (!rst_n) cnt = 0;
            else if (bus.mem_req) begin
                cnt++;
                if (cnt == 1) begin
                    if (exp_txn_q.size() == 0) chk("txn_spurious", 32'(bus.mem_req), 32'd0);
                    else begin
                        t = exp_txn_q.pop_front();
                        chk("mem_addr", bus.mem_addr, t.addr);
                        chk("mem_we", 32'(bus.mem_we), 32'(t.we));
                        chk("mem_wdata", bus.mem_wdata, t.wdata);
                        chk("mem_type", 32'(bus.mem_type), 32'(t.typ));
                    end
                end
                if (ack_after != 0 && cnt == ack_after) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = mem_model(bus.mem_addr);
                    last_len = cnt; cnt = 0;
                end
            end else begin
                if (cnt != 0) last_len = cnt;
                cnt = 0;
                if (idle_ack) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
                end
            end
        end
    end

    // Completion monitor: every valid pulse must match the head of its scoreboard queue.
    initial begin
        logic [31:0] e;
        dexp_t       de;
        forever begin
            @(negedge clk);
            if (!rst_n) exp_last = 32'h0;
            if (bus.if_valid) begin
                if (exp_if_q.size() == 0) chk("if_valid_spurious", 32'(bus.if_valid), 32'd0);
                else begin
                    e = exp_if_q.pop_front();
                    chk("if_rdata", bus.if_rdata, e);
                    done_log.push_back(0);
                end
            end
            if (bus.d_valid) begin
                if (exp_d_q.size() == 0) chk("d_valid_spurious", 32'(bus.d_valid), 32'd0);
                else begin
                    de = exp_d_q.pop_front();
                    if (!de.is_store) exp_last = de.rdata;
                    chk(de.is_store ? "d_rdata_store_kept" : "d_rdata_load", bus.d_rdata, exp_last);
                    done_log.push_back(1);
                end
            end
        end
    end

    initial begin
        int n;
        int got;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_d_valid", 32'(bus.d_valid), 32'd0);
        chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single fetch, ack on third mem_req cycle
        ack_after = 3;
        push_fetch(32'h100, 32'h13);
        n = 0; got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk); #1;
            if (bus.if_valid) got = 1;
            else begin
                chk("t1_stall", 32'(bus.stall), 32'd1);
                n++;
            end
        end
        chk("t1_valid_seen", got, 1);
        chk("t1_cycles_before_valid", n, 4);
        chk("t1_req_len", last_len, 3);
        @(negedge clk); #1;
        chk("t1_valid_one_cycle", 32'(bus.if_valid), 32'd0);
        chk("t1_stall_released", 32'(bus.stall), 32'd0);
        drain("t1", 20);

        // 2: simultaneous fetch and load, data first
        ack_after = 2;
        done_log.delete();
        @(posedge clk); #1;
        push_data(1'b1, 1'b0, 32'h2000, 32'h1111_1111, 3'b010, 1'b1);
        push_fetch(32'h104, mem_model(32'h104));
        drain("t2", 60);
        chk("t2_done_count", done_log.size(), 2);
        if (done_log.size() == 2) begin
            chk("t2_first_done_is_data", done_log[0], 1);
            chk("t2_second_done_is_fetch", done_log[1], 0);
        end

        // 3: back-to-back loads with fetch held: D,D,D,D,IF,D,D
        ack_after = 1;
        done_log.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) push_data(1'b1, 1'b0, 32'h3000 + 32'(4 * i), 32'h0, 3'b100, 1'b1);
        push_fetch(32'h108, mem_model(32'h108));
        for (int i = 0; i < 2; i++) begin
            d_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h3010 + 32'(4 * i), wdata: 32'h0, typ: 3'b100});
        end
        // The fetch transaction sits between the fourth and fifth data transactions.
        for (int i = 0; i < 2; i++) begin
            exp_txn_q.push_back('{we: 1'b0, addr: 32'h3010 + 32'(4 * i), wdata: 32'h0, typ: 3'b100});
            exp_d_q.push_back('{is_store: 1'b0, rdata: mem_model(32'h3010 + 32'(4 * i))});
        end
        drain("t3", 120);
        chk("t3_done_count", done_log.size(), 7);
        if (done_log.size() == 7) begin
            chk("t3_fifth_done_is_fetch", done_log[4], 0);
            chk("t3_sixth_done_is_data", done_log[5], 1);
        end

        // 4: stores, including rd_en and wr_en both high
        ack_after = 2;
        @(posedge clk); #1;
        push_data(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 3'b010, 1'b1);
        push_data(1'b1, 1'b1, 32'h44, 32'hCAFE_F00D, 3'b001, 1'b1);
        drain("t4", 60);
        chk("t4_d_rdata_unchanged", bus.d_rdata, mem_model(32'h3014));

        // mem_ack while idle is ignored
        idle_ack = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            chk("idle_ack_no_req", 32'(bus.mem_req), 32'd0);
            chk("idle_ack_no_valid", 32'(bus.if_valid | bus.d_valid), 32'd0);
        end
        idle_ack = 1'b0;

        // Ack on the abort cycle completes normally
        ack_after = 15;
        @(posedge clk); #1;
        push_fetch(32'h180, mem_model(32'h180));
        drain("t5a", 60);
        chk("t5a_req_len", last_len, 15);
        chk("t5a_no_timeout", 32'(bus.timeout_err), 32'd0);

        // 5: no ack -> abort after 15 cycles, sticky error, zero data
        ack_after = 0;
        @(posedge clk); #1;
        push_fetch(32'h200, 32'h0);
        drain("t5", 60);
        chk("t5_req_len", last_len, 15);
        chk("t5_timeout_set", 32'(bus.timeout_err), 32'd1);
        ack_after = 2;
        push_fetch(32'h204, mem_model(32'h204));
        drain("t5b", 30);
        chk("t5_timeout_sticky", 32'(bus.timeout_err), 32'd1);

        // 6: reset mid data transaction
        ack_after = 0;
        @(posedge clk); #1;
        push_data(1'b1, 1'b0, 32'h500, 32'h0, 3'b010, 1'b0);
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(negedge clk); #1;
            if (bus.mem_req) got = 1;
        end
        chk("t6_req_seen", got, 1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_req_drop_async", 32'(bus.mem_req), 32'd0);
        chk("t6_timeout_cleared", 32'(bus.timeout_err), 32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("t6_no_req_after_reset", 32'(bus.mem_req), 32'd0);
        ack_after = 2;
        push_data(1'b1, 1'b0, 32'h600, 32'h0, 3'b010, 1'b1);
        drain("t6", 30);
        chk("t6_new_load_data", bus.d_rdata, mem_model(32'h600));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
